ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Sequences the on-board DRAM and shares it between fast-bus CPU accesses and refresh. It consumes the fast-bus AS detection (`ASActive`/`ASInactive`) and the refresh handshake (`RefReq`/`RefUrgent`/`RefAck`) produced by the FSB block. It drives RAS/CAS/address-mux strobes, and returns `RAMReady` into the FSB `Ready` path. Refresh is CAS-before-RAS, so no refresh address counter is needed.

## Interface
- `TRP`, 2: precharge cycles after any RAS release (legal 1..7).
- `TRAS`, 4: cycles nRAS held low during refresh (legal 1..7).
- `FCLK`  in  1  fast bus clock; all logic on posedge.
- `Reset`  in  1  synchronous, active-high reset.
- `ASActive`  in  1  fast-bus AS asserted (from FSB).
- `ASInactive`  in  1  fast-bus AS fully negated (from FSB).
- `RAMCS`  in  1  current cycle decodes to DRAM.
- `nWE`  in  1  CPU write strobe, low = write.
- `nUDS`, `nLDS`  in  1 each  CPU byte-lane strobes, low active.
- `RefReq`  in  1  refresh wanted (from FSB).
- `RefUrgent`  in  1  refresh overdue; must preempt CPU.
- `RefAck`  out  1  one-cycle pulse: refresh completed.
- `RAMReady`  out  1  DRAM data valid / write accepted.
- `nRAS`  out  1  DRAM row strobe.
- `nCASH`, `nCASL`  out  1 each  DRAM column strobes, upper/lower byte.
- `RASMux`  out  1  0 = row address, 1 = column address.

## Operation
- All outputs are registered. Reset values: `nRAS`=1, `nCASH`=1, `nCASL`=1, `RASMux`=0, `RAMReady`=0, `RefAck`=0, state IDLE, counter 0.
- States: IDLE, ROW, COL, CAS, RCAS, RRAS, PRE.
- IDLE arbitration is evaluated each edge, in priority order:
  1. `RefUrgent` → RCAS.
  2. `ASActive && RAMCS` → ROW.
  3. `RefReq && !ASActive` → RCAS.
  4. Otherwise stay in IDLE.
- Tie rules:
  - `RefUrgent` and a CPU request on the same edge: refresh wins. The CPU request is held off because `RAMReady` stays 0.
  - Non-urgent `RefReq` and a CPU request on the same edge: the CPU wins.
- ROW: `nRAS`=0, `RASMux`=0. Next state is COL.
- COL: `RASMux`=1. Next state is CAS.
- CAS: assert the column strobes and `RAMReady`=1, then hold while AS is not `ASInactive`.
  - Write (`nWE`=0): `nCASH`=`nUDS` and `nCASL`=`nLDS`, sampled on entry.
  - Read: both CAS strobes go low.
- Abort: `ASInactive` seen in ROW, COL or CAS releases all strobes on the next edge. That edge sets `RASMux`=0 and `RAMReady`=0, then the state goes to PRE. If both `ASActive` and `ASInactive` are 0 (AS transition window), the state is held.
- RCAS: `nCASH`=`nCASL`=0. Next state is RRAS.
- RRAS: `nRAS`=0 and the counter loads `TRAS`. The counter decrements each cycle.
- Refresh completion: on the edge where the RRAS count expires, all strobes release, `RefAck`=1 for exactly that cycle, and the state goes to PRE.
- RRAS ignores AS activity. A CPU RAM cycle arriving during refresh waits in IDLE arbitration.
- PRE: all strobes high, the counter loads `TRP` on entry and decrements. When the count expires the state goes to IDLE. No back-to-back RAS without `TRP` precharge.
- `Reset` asserted in any state forces the reset values on that edge, including mid-refresh. `RefAck` is not pulsed for an interrupted refresh.
- Counter is 3 bits and does not wrap; it only reloads on state entry.

## Timing
- CPU read, edge n = IDLE sees the request:
  - n: `nRAS`↓.
  - n+1: `RASMux`↑.
  - n+2: CAS↓ and `RAMReady`↑.
  - The FSB then asserts DTACK on edge n+3.
- CPU release: edge m = first `ASInactive` in CAS.
  - m: strobes↑ and `RAMReady`↓.
  - PRE spans edges m..m+`TRP`; IDLE is at edge m+`TRP`.
  - With defaults, the earliest new `nRAS`↓ is edge m+3.
- Refresh, edge r = IDLE grant:
  - r: CAS↓.
  - r+1: `nRAS`↓.
  - r+1+`TRAS`: release and `RefAck` pulse.
  - IDLE at r+1+2·… no; IDLE at r+1+`TRAS`+`TRP`. With defaults that is r+7.
- `RefAck` is high for 1 cycle only. The FSB's `RefReq` drops on the following edge, so no duplicate refresh occurs.
- Worst-case added CPU latency from an urgent refresh is 2+`TRAS`+`TRP` cycles.

## Test plan
- Reset held 3 cycles, then released with inputs idle → all outputs at reset values, no strobe activity, `RefAck`=0.
- Read cycle: `ASActive`=1, `RAMCS`=1, `nWE`=1 at edge 0 → `nRAS`=0 @0, `RASMux`=1 @1, `nCASH`=`nCASL`=0 and `RAMReady`=1 @2. `ASInactive` @5 → strobes high @5, IDLE @7.
- Byte write: `nWE`=0, `nUDS`=1, `nLDS`=0 → at CAS, `nCASL`=0 and `nCASH`=1.
- Idle refresh: `RefReq`=1, AS idle, at edge 0 → CAS low @0, `nRAS` low @1, release with `RefAck`=1 @5 (single cycle), IDLE @7.
- Contention:
  - `RefUrgent`=1 and a RAM request on the same edge → refresh sequence first, `RAMReady` stays 0, CPU cycle `nRAS`↓ on the first IDLE edge after precharge.
  - Same with only `RefReq` → CPU cycle first.
- Abort and reset:
  - `ASInactive` in COL → no CAS assertion, PRE then IDLE.
  - `Reset` during RRAS → strobes high next edge, no `RefAck`.

Source files
------------

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - DRAM sequencer sharing the array between fast-bus CPU cycles and CAS-before-RAS refresh
module ram_arbiter #(
  parameter int TRP  = 2,
  parameter int TRAS = 4
) (
  input  logic FCLK,
  input  logic Reset,
  input  logic ASActive,
  input  logic ASInactive,
  input  logic RAMCS,
  input  logic nWE,
  input  logic nUDS,
  input  logic nLDS,
  input  logic RefReq,
  input  logic RefUrgent,
  output logic RefAck,
  output logic RAMReady,
  output logic nRAS,
  output logic nCASH,
  output logic nCASL,
  output logic RASMux
);

  localparam logic [2:0] TRP_L  = 3'(TRP);
  localparam logic [2:0] TRAS_L = 3'(TRAS);

  typedef enum logic [2:0] {IDLE, ROW, COL, CAS, RCAS, RRAS, PRE} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       nras_nxt, ncash_nxt, ncasl_nxt, rasmux_nxt, ready_nxt, ref_ack_nxt;
  logic       go_pre;

  // Next state and next registered strobes; each transition sets the outputs of the state it enters
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    nras_nxt    = nRAS;
    ncash_nxt   = nCASH;
    ncasl_nxt   = nCASL;
    rasmux_nxt  = RASMux;
    ready_nxt   = RAMReady;
    ref_ack_nxt = 1'b0;
    go_pre      = 1'b0;

    // Timed states count down toward 1 and saturate; reloads only happen on entry
    if ((state == RRAS || state == PRE) && cnt != 3'd0)
      cnt_nxt = cnt - 3'd1;

    case (state)
      IDLE: begin
        if (RefUrgent) begin
          state_nxt = RCAS;
          ncash_nxt = 1'b0;
          ncasl_nxt = 1'b0;
        end else if (ASActive && RAMCS) begin
          state_nxt  = ROW;
          nras_nxt   = 1'b0;
          rasmux_nxt = 1'b0;
        end else if (RefReq && !ASActive) begin
          state_nxt = RCAS;
          ncash_nxt = 1'b0;
          ncasl_nxt = 1'b0;
        end
      end
      ROW: begin
        if (ASInactive) begin
          go_pre = 1'b1;
        end else if (ASActive) begin
          state_nxt  = COL;
          rasmux_nxt = 1'b1;
        end
      end
      COL: begin
        if (ASInactive) begin
          go_pre = 1'b1;
        end else if (ASActive) begin
          state_nxt = CAS;
          ready_nxt = 1'b1;
          // Byte lanes are captured here and held for the whole CAS phase
          ncash_nxt = nWE ? 1'b0 : nUDS;
          ncasl_nxt = nWE ? 1'b0 : nLDS;
        end
      end
      CAS: begin
        if (ASInactive)
          go_pre = 1'b1;
      end
      RCAS: begin
        state_nxt = RRAS;
        nras_nxt  = 1'b0;
        cnt_nxt   = TRAS_L;
      end
      RRAS: begin
        if (cnt <= 3'd1) begin
          go_pre      = 1'b1;
          ref_ack_nxt = 1'b1;
        end
      end
      PRE: begin
        if (cnt <= 3'd1)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Common release path: all strobes high and precharge timer started
    if (go_pre) begin
      state_nxt  = PRE;
      cnt_nxt    = TRP_L;
      nras_nxt   = 1'b1;
      ncash_nxt  = 1'b1;
      ncasl_nxt  = 1'b1;
      rasmux_nxt = 1'b0;
      ready_nxt  = 1'b0;
    end
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge FCLK) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      nRAS     <= 1'b1;
      nCASH    <= 1'b1;
      nCASL    <= 1'b1;
      RASMux   <= 1'b0;
      RAMReady <= 1'b0;
      RefAck   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      nRAS     <= nras_nxt;
      nCASH    <= ncash_nxt;
      nCASL    <= ncasl_nxt;
      RASMux   <= rasmux_nxt;
      RAMReady <= ready_nxt;
      RefAck   <= ref_ack_nxt;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter
module tb_ram_arbiter;

  logic FCLK, Reset, ASActive, ASInactive, RAMCS, nWE, nUDS, nLDS, RefReq, RefUrgent;
  logic RefAck, RAMReady, nRAS, nCASH, nCASL, RASMux;
  logic [5:0] outs;
  int checks;
  int failures;

  ram_arbiter #(.TRP(2), .TRAS(4)) dut (
    .FCLK(FCLK), .Reset(Reset), .ASActive(ASActive), .ASInactive(ASInactive),
    .RAMCS(RAMCS), .nWE(nWE), .nUDS(nUDS), .nLDS(nLDS), .RefReq(RefReq),
    .RefUrgent(RefUrgent), .RefAck(RefAck), .RAMReady(RAMReady), .nRAS(nRAS),
    .nCASH(nCASH), .nCASL(nCASL), .RASMux(RASMux)
  );

  // Bit order: {nRAS, nCASH, nCASL, RASMux, RAMReady, RefAck}
  assign outs = {nRAS, nCASH, nCASL, RASMux, RAMReady, RefAck};

  initial FCLK = 1'b0;
  always #5 FCLK = ~FCLK;

  task automatic tick;
    @(posedge FCLK);
    #1;
  endtask

  task automatic idle_inputs;
    ASActive = 1'b0; ASInactive = 1'b1; RAMCS = 1'b0;
    nWE = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
    RefReq = 1'b0; RefUrgent = 1'b0;
  endtask

  task automatic cpu_req(input logic we_n, input logic uds_n, input logic lds_n);
    ASActive = 1'b1; ASInactive = 1'b0; RAMCS = 1'b1;
    nWE = we_n; nUDS = uds_n; nLDS = lds_n;
  endtask

  task automatic cpu_release;
    ASActive = 1'b0; ASInactive = 1'b1; RAMCS = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    Reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) Reset = 1'b0;
      tick();
      checks++;
      if (outs !== 6'b111000) begin
        failures++;
        $display("FAIL reset cycle%0d outs=%b expected=%b", i, outs, 6'b111000);
      end
    end
  endtask

  task automatic test_read;
    logic [5:0] want [0:11];
    want = '{6'b011000, 6'b011100, 6'b000110, 6'b000110, 6'b000110, 6'b111000,
             6'b111000, 6'b111000, 6'b011000, 6'b111000, 6'b111000, 6'b111000};
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: cpu_req(1'b1, 1'b1, 1'b1);
        5: cpu_release();
        6: cpu_req(1'b1, 1'b1, 1'b1);
        9: cpu_release();
        default: ;
      endcase
      tick();
      checks++;
      if (outs !== want[i]) begin
        failures++;
        $display("FAIL read edge%0d outs=%b expected=%b", i, outs, want[i]);
      end
    end
  endtask

  task automatic test_byte_write;
    logic [5:0] want [0:7];
    want = '{6'b011000, 6'b011100, 6'b010110, 6'b010110,
             6'b010110, 6'b111000, 6'b111000, 6'b111000};
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: cpu_req(1'b0, 1'b1, 1'b0);
        3: begin ASActive = 1'b0; ASInactive = 1'b0; nUDS = 1'b0; nLDS = 1'b1; end
        5: begin cpu_release(); nWE = 1'b1; nUDS = 1'b1; nLDS = 1'b1; end
        default: ;
      endcase
      tick();
      checks++;
      if (outs !== want[i]) begin
        failures++;
        $display("FAIL byte_write edge%0d outs=%b expected=%b", i, outs, want[i]);
      end
    end
  endtask

  task automatic test_idle_refresh;
    logic [5:0] want [0:11];
    want = '{6'b100000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b111001,
             6'b111000, 6'b111000, 6'b011000, 6'b111000, 6'b111000, 6'b111000};
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: RefReq = 1'b1;
        6: begin RefReq = 1'b0; cpu_req(1'b1, 1'b1, 1'b1); end
        9: cpu_release();
        default: ;
      endcase
      tick();
      checks++;
      if (outs !== want[i]) begin
        failures++;
        $display("FAIL idle_refresh edge%0d outs=%b expected=%b", i, outs, want[i]);
      end
    end
  endtask

  task automatic test_urgent_contention;
    logic [5:0] want [0:13];
    want = '{6'b100000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b111001, 6'b111000,
             6'b111000, 6'b011000, 6'b011100, 6'b000110, 6'b111000, 6'b111000, 6'b111000};
    for (int i = 0; i < 14; i++) begin
      case (i)
        0:  begin RefUrgent = 1'b1; cpu_req(1'b1, 1'b1, 1'b1); end
        1:  RefUrgent = 1'b0;
        11: cpu_release();
        default: ;
      endcase
      tick();
      checks++;
      if (outs !== want[i]) begin
        failures++;
        $display("FAIL urgent_contention edge%0d outs=%b expected=%b", i, outs, want[i]);
      end
    end
  endtask

  task automatic test_refreq_contention;
    logic [5:0] want [0:13];
    want = '{6'b011000, 6'b011100, 6'b000110, 6'b111000, 6'b111000, 6'b111000, 6'b100000,
             6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b111001, 6'b111000, 6'b111000};
    for (int i = 0; i < 14; i++) begin
      case (i)
        0: begin RefReq = 1'b1; cpu_req(1'b1, 1'b1, 1'b1); end
        3: cpu_release();
        7: RefReq = 1'b0;
        default: ;
      endcase
      tick();
      checks++;
      if (outs !== want[i]) begin
        failures++;
        $display("FAIL refreq_contention edge%0d outs=%b expected=%b", i, outs, want[i]);
      end
    end
  endtask

  task automatic test_abort_col;
    logic [5:0] want [0:8];
    want = '{6'b011000, 6'b011100, 6'b111000, 6'b111000, 6'b111000,
             6'b011000, 6'b111000, 6'b111000, 6'b111000};
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: cpu_req(1'b1, 1'b1, 1'b1);
        2: cpu_release();
        3: cpu_req(1'b1, 1'b1, 1'b1);
        6: cpu_release();
        default: ;
      endcase
      tick();
      checks++;
      if (outs !== want[i]) begin
        failures++;
        $display("FAIL abort_col edge%0d outs=%b expected=%b", i, outs, want[i]);
      end
    end
  endtask

  task automatic test_reset_rras;
    logic [5:0] want [0:7];
    want = '{6'b100000, 6'b000000, 6'b000000, 6'b111000,
             6'b111000, 6'b111000, 6'b111000, 6'b111000};
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: RefReq = 1'b1;
        3: begin Reset = 1'b1; RefReq = 1'b0; end
        4: Reset = 1'b0;
        default: ;
      endcase
      tick();
      checks++;
      if (outs !== want[i]) begin
        failures++;
        $display("FAIL reset_rras edge%0d outs=%b expected=%b", i, outs, want[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    Reset = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_read();
    test_byte_write();
    test_idle_refresh();
    test_urgent_contention();
    test_refreq_contention();
    test_abort_col();
    test_reset_rras();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
